// File: rtl/period_duty_meter_if.sv
// rtl/period_duty_meter_if.sv - control and result bundle for the period/duty meter
//
// Ports:
//   f_in_gate   measured signal, asynchronous to the count clock
//   start       one-cycle request to begin a measurement
//   cont        continuous mode, re-arm after every result or timeout
//   period_out  count-clock cycles spanned by the averaged input periods
//   high_out    count-clock cycles with the input high in the same window
//   valid       one-cycle result strobe
//   timeout     one-cycle abort strobe
//   busy        measurement armed or in progress
interface period_duty_meter_if #(
    parameter int CNT_W = 32
);
    logic             f_in_gate;
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             timeout;
    logic             busy;

    modport master (
        output f_in_gate, start, cont,
        input  period_out, high_out, valid, timeout, busy
    );

    modport slave (
        input  f_in_gate, start, cont,
        output period_out, high_out, valid, timeout, busy
    );
endinterface

// File: rtl/period_duty_meter.sv
// rtl/period_duty_meter.sv - input period and high-time meter with averaging and timeout
//
// Ports:
//   sys_count_clk  single clock; all logic on its rising edge
//   rst_n          asynchronous active-low reset
//   bus            period_duty_meter_if.slave (f_in_gate, start, cont in;
//                  period_out, high_out, valid, timeout, busy out)
module period_duty_meter #(
    parameter int CNT_W    = 32,
    parameter int AVG_LOG2 = 0,
    parameter int TIMEOUT  = 50_000_000
) (
    input  logic               sys_count_clk,
    input  logic               rst_n,
    period_duty_meter_if.slave bus
);
    // One spare bit keeps the edge counter legal when AVG_LOG2 is 0.
    localparam int                EDGE_W    = AVG_LOG2 + 1;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t            state, state_n;
    logic              sync_1, sig_s, sig_p;
    logic              rise, terminal, at_limit;
    logic [CNT_W-1:0]  cnt_p, cnt_p_n;
    logic [CNT_W-1:0]  cnt_h, cnt_h_n;
    logic [CNT_W-1:0]  period_n, high_n;
    logic [EDGE_W-1:0] edge_cnt, edge_cnt_n;
    logic              valid_n, timeout_n;

    assign rise     = sig_s & ~sig_p;
    assign terminal = (state == MEAS) && rise && (edge_cnt == EDGE_LAST);
    assign at_limit = (cnt_p == CNT_LIMIT);
    assign bus.busy = (state != IDLE);

    always_comb begin
        state_n    = state;
        cnt_p_n    = cnt_p;
        cnt_h_n    = cnt_h;
        edge_cnt_n = edge_cnt;
        period_n   = bus.period_out;
        high_n     = bus.high_out;
        valid_n    = 1'b0;
        timeout_n  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ARM;
                    cnt_p_n = '0;
                end
            end
            ARM: begin
                // In ARM a rise is never terminal, so the limit wins.
                if (at_limit) begin
                    timeout_n = 1'b1;
                    period_n  = '0;
                    high_n    = '0;
                    cnt_p_n   = '0;
                    state_n   = bus.cont ? ARM : IDLE;
                end else if (rise) begin
                    state_n    = MEAS;
                    cnt_p_n    = CNT_ONE;
                    cnt_h_n    = CNT_ONE;
                    edge_cnt_n = '0;
                end else begin
                    cnt_p_n = cnt_p + CNT_ONE;
                end
            end
            MEAS: begin
                if (terminal) begin
                    // The rise cycle opens the next window: counts restart at 1,
                    // so back-to-back results have no gap.
                    period_n   = cnt_p;
                    high_n     = cnt_h;
                    valid_n    = 1'b1;
                    cnt_p_n    = CNT_ONE;
                    cnt_h_n    = CNT_ONE;
                    edge_cnt_n = '0;
                    state_n    = bus.cont ? MEAS : IDLE;
                end else if (at_limit) begin
                    timeout_n = 1'b1;
                    period_n  = '0;
                    high_n    = '0;
                    cnt_p_n   = '0;
                    state_n   = bus.cont ? ARM : IDLE;
                end else begin
                    cnt_p_n = cnt_p + CNT_ONE;
                    cnt_h_n = cnt_h + CNT_W'(sig_s);
                    if (rise) begin
                        edge_cnt_n = edge_cnt + EDGE_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_count_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sync_1         <= 1'b0;
            sig_s          <= 1'b0;
            sig_p          <= 1'b0;
            cnt_p          <= '0;
            cnt_h          <= '0;
            edge_cnt       <= '0;
            bus.period_out <= '0;
            bus.high_out   <= '0;
            bus.valid      <= 1'b0;
            bus.timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            sync_1         <= bus.f_in_gate;
            sig_s          <= sync_1;
            sig_p          <= sig_s;
            cnt_p          <= cnt_p_n;
            cnt_h          <= cnt_h_n;
            edge_cnt       <= edge_cnt_n;
            bus.period_out <= period_n;
            bus.high_out   <= high_n;
            bus.valid      <= valid_n;
            bus.timeout    <= timeout_n;
        end
    end
endmodule

// File: tb/tb_period_duty_meter.sv
// tb/tb_period_duty_meter.sv - directed self-checking bench for period_duty_meter
module tb_period_duty_meter;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic f_in  = 1'b0;

    always #5 clk = ~clk;

    period_duty_meter_if #(.CNT_W(CNT_W)) if0 ();
    period_duty_meter_if #(.CNT_W(CNT_W)) if2 ();

    assign if0.f_in_gate = f_in;
    assign if2.f_in_gate = f_in;

    period_duty_meter #(.CNT_W(CNT_W), .AVG_LOG2(0), .TIMEOUT(TIMEOUT)) dut0 (
        .sys_count_clk(clk),
        .rst_n        (rst_n),
        .bus          (if0)
    );

    period_duty_meter #(.CNT_W(CNT_W), .AVG_LOG2(2), .TIMEOUT(TIMEOUT)) dut2 (
        .sys_count_clk(clk),
        .rst_n        (rst_n),
        .bus          (if2)
    );

    // Input waveform: period and high time are latched at each rising edge.
    int gen_per = 100;
    int gen_hi  = 30;
    bit gen_en  = 1'b0;

    always begin : gen
        int p;
        int h;
        if (gen_en) begin
            p = gen_per;
            h = gen_hi;
            @(negedge clk);
            f_in = 1'b1;
            repeat (h) @(negedge clk);
            f_in = 1'b0;
            repeat (p - h - 1) @(negedge clk);
        end else begin
            @(negedge clk);
            f_in = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input bit s0, input bit s2);
        @(negedge clk);
        if0.start = s0;
        if2.start = s2;
        @(negedge clk);
        if0.start = 1'b0;
        if2.start = 1'b0;
    endtask

    task automatic wait_evt(input int sel, input int budget,
                            output bit got_v, output bit got_t, output int cyc);
        got_v = 1'b0;
        got_t = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (sel == 0) begin
                got_v = if0.valid;
                got_t = if0.timeout;
            end else begin
                got_v = if2.valid;
                got_t = if2.timeout;
            end
            if (got_v || got_t) begin
                cyc = k;
                return;
            end
        end
    endtask

    task automatic count_evts(input int sel, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (sel == 0) cnt += int'(if0.valid) + int'(if0.timeout);
            else          cnt += int'(if2.valid) + int'(if2.timeout);
        end
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        bit v;
        bit t;
        int c;
        int n;

        if0.start = 1'b0;
        if0.cont  = 1'b0;
        if2.start = 1'b0;
        if2.cont  = 1'b0;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", if0.period_out, 0);
        check("rst_high",   if0.high_out,   0);
        check("rst_valid",  if0.valid,      0);
        check("rst_timeout", if0.timeout,   0);
        check("rst_busy",   if0.busy,       0);
        check("rst_busy2",  if2.busy,       0);
        rst_n = 1'b1;

        // single measurement, N=1 and N=4, period 100 high 30
        gen_per = 100;
        gen_hi  = 30;
        gen_en  = 1'b1;
        repeat (20) @(negedge clk);
        pulse_start(1'b1, 1'b1);
        wait_evt(0, 400, v, t, c);
        check("n1_valid",  v, 1);
        check("n1_period", if0.period_out, 100);
        check("n1_high",   if0.high_out,   30);
        @(negedge clk);
        check("n1_idle", if0.busy, 0);
        wait_evt(1, 700, v, t, c);
        check("n4_valid",  v, 1);
        check("n4_period", if2.period_out, 400);
        check("n4_high",   if2.high_out,   120);
        @(negedge clk);
        check("n4_idle", if2.busy, 0);
        count_evts(1, 300, n);
        check("n4_single", n, 0);

        // timeout with input held low
        gen_en = 1'b0;
        repeat (150) @(negedge clk);
        pulse_start(1'b1, 1'b0);
        wait_evt(0, 1100, v, t, c);
        check("to_seen",    t, 1);
        check("to_novalid", v, 0);
        check("to_latency", c, 1001);
        check("to_period",  if0.period_out, 0);
        check("to_high",    if0.high_out,   0);
        @(negedge clk);
        check("to_idle",  if0.busy,    0);
        check("to_pulse", if0.timeout, 0);

        // terminal rise exactly at the limit is a result (4 x 250 = 1000)
        gen_per = 250;
        gen_hi  = 100;
        gen_en  = 1'b1;
        repeat (300) @(negedge clk);
        pulse_start(1'b0, 1'b1);
        wait_evt(1, 2500, v, t, c);
        check("lim_valid",   v, 1);
        check("lim_timeout", t, 0);
        check("lim_period",  if2.period_out, 1000);
        check("lim_high",    if2.high_out,   400);

        // one cycle longer window (4 x 251) must time out
        gen_per = 251;
        repeat (300) @(negedge clk);
        pulse_start(1'b0, 1'b1);
        wait_evt(1, 2500, v, t, c);
        check("over_timeout", t, 1);
        check("over_valid",   v, 0);
        check("over_period",  if2.period_out, 0);
        check("over_high",    if2.high_out,   0);

        // continuous mode, period 100 high 50
        gen_per = 100;
        gen_hi  = 50;
        repeat (300) @(negedge clk);
        if0.cont = 1'b1;
        pulse_start(1'b1, 1'b0);
        wait_evt(0, 400, v, t, c);
        check("cont_first", v, 1);
        check("cont_first_period", if0.period_out, 100);
        check("cont_first_high",   if0.high_out,   50);
        for (int i = 0; i < 2; i++) begin
            wait_evt(0, 150, v, t, c);
            check("cont_valid",  v, 1);
            check("cont_gap",    c, 100);
            check("cont_period", if0.period_out, 100);
            check("cont_high",   if0.high_out,   50);
        end
        if0.cont = 1'b0;
        wait_evt(0, 150, v, t, c);
        check("cont_last_valid",  v, 1);
        check("cont_last_gap",    c, 100);
        check("cont_last_period", if0.period_out, 100);
        check("cont_last_high",   if0.high_out,   50);
        @(negedge clk);
        check("cont_idle", if0.busy, 0);
        count_evts(0, 300, n);
        check("cont_quiet", n, 0);

        // period change 100 -> 200 in continuous mode
        if0.cont = 1'b1;
        pulse_start(1'b1, 1'b0);
        wait_evt(0, 400, v, t, c);
        check("chg_a_period", if0.period_out, 100);
        gen_per = 200;
        wait_evt(0, 250, v, t, c);
        check("chg_b_valid",  v, 1);
        check("chg_b_period", if0.period_out, 100);
        check("chg_b_high",   if0.high_out,   50);
        wait_evt(0, 250, v, t, c);
        check("chg_c_valid",  v, 1);
        check("chg_c_period", if0.period_out, 200);
        check("chg_c_high",   if0.high_out,   50);
        if0.cont = 1'b0;
        wait_evt(0, 250, v, t, c);
        check("chg_d_period", if0.period_out, 200);
        @(negedge clk);
        check("chg_idle", if0.busy, 0);

        // asynchronous reset in the middle of a measurement
        gen_per = 100;
        gen_hi  = 30;
        repeat (300) @(negedge clk);
        @(posedge f_in);
        pulse_start(1'b1, 1'b0);
        repeat (150) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_period",  if0.period_out, 0);
        check("arst_high",    if0.high_out,   0);
        check("arst_busy",    if0.busy,       0);
        check("arst_valid",   if0.valid,      0);
        check("arst_timeout", if0.timeout,    0);
        @(negedge clk);
        rst_n = 1'b1;
        count_evts(0, 400, n);
        check("arst_quiet", n, 0);
        pulse_start(1'b1, 1'b0);
        wait_evt(0, 400, v, t, c);
        check("arst_valid_after", v, 1);
        check("arst_period_after", if0.period_out, 100);
        check("arst_high_after",   if0.high_out,   30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/period_duty_meter.md
PERIOD_DUTY_METER -- requirements
Module: period_duty_meter

Interface
REQ-001 Parameter CNT_W, default 32: width of all cycle counters and result outputs.
REQ-002 Parameter AVG_LOG2, default 0: each measurement spans N = 2^AVG_LOG2 consecutive input periods.
REQ-003 Parameter TIMEOUT, default 50_000_000: cycle limit per measurement; the design SHALL be used only with TIMEOUT < 2^CNT_W - 1.
REQ-004 sys_count_clk  in  1  single system/count clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 f_in_gate  in  1  measured signal, asynchronous to sys_count_clk.
REQ-007 start  in  1  one-cycle request to begin a measurement; ignored while busy=1.
REQ-008 cont  in  1  continuous mode; 1 = re-arm automatically after each result.
REQ-009 period_out  out  CNT_W  sys_count_clk cycles spanned by N input periods.
REQ-010 high_out  out  CNT_W  sys_count_clk cycles with the input high within the same N periods.
REQ-011 valid  out  1  one-cycle pulse; period_out/high_out updated in the same cycle.
REQ-012 timeout  out  1  one-cycle pulse; measurement aborted.
REQ-013 busy  out  1  high in ARM and MEAS states.

Function
REQ-014 f_in_gate SHALL pass through a 2-flop synchronizer (sig_s), then one more register (sig_p); rise = sig_s & !sig_p; all logic SHALL be clocked by sys_count_clk only, with no derived clocks.
REQ-015 FSM states: IDLE, ARM, MEAS; IDLE->ARM on start; on ARM entry, cnt_p SHALL clear to 0.
REQ-016 ARM: cnt_p += 1 each cycle; on rise -> MEAS with cnt_p=1, cnt_h=1, edge_cnt=0.
REQ-017 MEAS, each cycle without rise: cnt_p += 1, cnt_h += sig_s.
REQ-018 MEAS on rise with edge_cnt < N-1: edge_cnt += 1, counting continues per REQ-017.
REQ-019 MEAS on rise with edge_cnt == N-1 (terminal): period_out <= cnt_p, high_out <= cnt_h, valid=1; the rise cycle itself SHALL NOT be included in the result.
REQ-020 After terminal rise: cont=1 -> stay MEAS with cnt_p=1, cnt_h=1, edge_cnt=0, giving gapless back-to-back results; cont=0 -> IDLE.
REQ-021 Timeout: in ARM or MEAS, when cnt_p == TIMEOUT and the cycle is not a terminal rise, the block SHALL pulse timeout, set period_out=0 and high_out=0, keep valid=0, then go to ARM if cont=1 (cnt_p cleared), else IDLE.
REQ-022 A terminal rise coinciding with cnt_p == TIMEOUT SHALL count as a valid result, not a timeout.
REQ-023 cont SHALL be sampled only at result/timeout events; deasserting mid-measurement finishes the current measurement, then goes IDLE.
REQ-024 start while busy SHALL have no effect; start and terminal rise in the same cycle SHALL leave cont governing the result.
REQ-025 valid and timeout SHALL never be high in the same cycle; outputs SHALL hold between events.
REQ-026 Result latency: valid asserts 3 sys_count_clk cycles after the f_in_gate rising edge that ends the Nth period (sync 2 + detect 1).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and period_out=0, high_out=0, valid=0, timeout=0, busy=0, and all counters and synchronizer flops to 0.
REQ-028 Reset mid-measurement SHALL discard the partial count; no valid after release until a new start.

Verification
REQ-029 AVG_LOG2=0, TIMEOUT=1000, input period 100 cycles / high 30, start -> valid pulse with period_out=100, high_out=30.
REQ-030 AVG_LOG2=2, same input -> single valid with period_out=400, high_out=120.
REQ-031 TIMEOUT=1000, input held low, start, cont=0 -> timeout pulse 1001 cycles after ARM entry, valid=0, outputs 0, busy=0 afterwards.
REQ-032 cont=1, period 100 / high 50 -> valid every 100 cycles, each with 100/50; drop cont -> one more result, then busy=0.
REQ-033 rst_n pulsed low mid-MEAS -> all outputs 0 asynchronously; no valid until new start; next result correct.
REQ-034 Input period changes 100 -> 200 between results in cont mode -> successive results 100 then 200, no merged or partial value.
